// File: rtl/eth_crc32_engine_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet CRC-32 engine.
package eth_crc32_engine_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StAccum = 2'd1;
  localparam state_t StFcsTx = 2'd2;
  localparam state_t StDone  = 2'd3;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_engine_if.sv
// Frame-data, FCS-stream and status bundle of the CRC-32 engine.
interface eth_crc32_engine_if #(
  parameter int unsigned DATA_W = 4
);

  logic              start;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              din_last;
  logic              fcs_ready;
  logic              fcs_valid;
  logic [DATA_W-1:0] fcs_data;
  logic [31:0]       crc_out;
  logic              done;
  logic              crc_ok;
  logic              busy;

  modport master (
    output start, din_valid, din, din_last, fcs_ready,
    input  fcs_valid, fcs_data, crc_out, done, crc_ok, busy
  );

  modport slave (
    input  start, din_valid, din, din_last, fcs_ready,
    output fcs_valid, fcs_data, crc_out, done, crc_ok, busy
  );

endinterface

// File: rtl/eth_crc32_engine_crc32_step.sv
// Combinational CRC-32 update over DATA_W bits, data bit 0 applied first.
module crc32_step
  import eth_crc32_engine_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [31:0]       crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [31:0]       crc_o
);

  logic [31:0] acc;
  logic        fb;

  always_comb begin
    acc = crc_i;
    fb  = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      fb  = acc[31] ^ data_i[i];
      acc = {acc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
    end
    crc_o = acc;
  end

endmodule

// File: rtl/eth_crc32_engine.sv
// Ethernet CRC-32 engine: accumulates frame data, optionally serialises the FCS,
// and reports the residue check when the frame closes.
module eth_crc32_engine
  import eth_crc32_engine_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned MODE_TX = 1
) (
  input  logic               clk,
  input  logic               reset,
  eth_crc32_engine_if.slave  bus
);

  localparam int unsigned NumBeats = 32 / DATA_W;
  localparam int unsigned KW       = $clog2(NumBeats);
  localparam logic [KW-1:0] LastBeat = KW'(NumBeats - 1);

  state_t            state_q, state_d;
  logic [31:0]       crc_q, crc_d;
  logic [31:0]       fcs_q, fcs_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] fcs_slice;
  logic [DATA_W-1:0] step_data;
  logic [31:0]       step_crc;
  logic              in_fcs;

  assign in_fcs    = (MODE_TX != 0) && (state_q == StFcsTx);
  assign fcs_slice = fcs_q[32'(k_q) * DATA_W +: DATA_W];
  // Emitted FCS beats run through the same update so the register lands on the residue.
  assign step_data = (state_q == StFcsTx) ? fcs_slice : bus.din;

  crc32_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .crc_i  (crc_q),
    .data_i (step_data),
    .crc_o  (step_crc)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    fcs_d   = fcs_q;
    k_d     = k_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAccum;
          crc_d   = CRC32_INIT;
        end
      end
      StAccum: begin
        if (bus.start) begin
          crc_d = CRC32_INIT;
          k_d   = '0;
        end else if (bus.din_valid) begin
          crc_d = step_crc;
          if (bus.din_last) begin
            if (MODE_TX != 0) begin
              state_d = StFcsTx;
              fcs_d   = bitrev32(~step_crc);
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StFcsTx: begin
        if (bus.start) begin
          state_d = StAccum;
          crc_d   = CRC32_INIT;
          k_d     = '0;
        end else if (bus.fcs_ready) begin
          crc_d = step_crc;
          if (k_q == LastBeat) begin
            k_d     = '0;
            state_d = StDone;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.start) begin
          state_d = StAccum;
          crc_d   = CRC32_INIT;
          k_d     = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      crc_q   <= CRC32_INIT;
      fcs_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      fcs_q   <= fcs_d;
      k_q     <= k_d;
    end
  end

  assign bus.fcs_valid = in_fcs;
  assign bus.fcs_data  = in_fcs ? fcs_slice : '0;
  assign bus.crc_out   = bitrev32(~crc_q);
  assign bus.done      = (state_q == StDone);
  assign bus.crc_ok    = (state_q == StDone) && (crc_q == CRC32_RESIDUE);
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_eth_crc32_engine.sv
// Directed bench: four engine instances (8/4-bit, check/transmit) on one clock and reset.
module tb_eth_crc32_engine;

  logic clk;
  logic reset;

  // Index: 0 = 8-bit check, 1 = 4-bit check, 2 = 8-bit transmit, 3 = 4-bit transmit.
  logic        start_a [4];
  logic        dv_a    [4];
  logic [7:0]  din_a   [4];
  logic        last_a  [4];
  logic        rdy_a   [4];
  logic        fv_a    [4];
  logic [7:0]  fd_a    [4];
  logic [31:0] crc_a   [4];
  logic        done_a  [4];
  logic        ok_a    [4];
  logic        busy_a  [4];

  int n_chk;
  int n_fail;
  logic [7:0] frame [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned DW = (g % 2 == 0) ? 8 : 4;
    localparam int unsigned MT = g / 2;

    eth_crc32_engine_if #(.DATA_W(DW)) bus ();

    eth_crc32_engine #(
      .DATA_W  (DW),
      .MODE_TX (MT)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.start     = start_a[g];
    assign bus.din_valid = dv_a[g];
    assign bus.din       = din_a[g][DW-1:0];
    assign bus.din_last  = last_a[g];
    assign bus.fcs_ready = rdy_a[g];
    assign fv_a[g]       = bus.fcs_valid;
    assign fd_a[g]       = 8'(bus.fcs_data);
    assign crc_a[g]      = bus.crc_out;
    assign done_a[g]     = bus.done;
    assign ok_a[g]       = bus.crc_ok;
    assign busy_a[g]     = bus.busy;
  end

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      start_a[i] = 1'b0;
      dv_a[i]    = 1'b0;
      din_a[i]   = 8'h00;
      last_a[i]  = 1'b0;
      rdy_a[i]   = 1'b0;
    end
  endtask

  task automatic pulse_start(input int i);
    start_a[i] = 1'b1;
    step();
    start_a[i] = 1'b0;
  endtask

  task automatic load_msg();
    frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  // Sends the queued bytes; 4-bit instances get the low nibble first.
  task automatic send_frame(input int i, input bit with_last);
    int nb;
    nb = (i % 2 == 0) ? 1 : 2;
    for (int b = 0; b < frame.size(); b++) begin
      for (int h = 0; h < nb; h++) begin
        bit fin;
        fin = with_last && (b == frame.size() - 1) && (h == nb - 1);
        if (nb == 1) din_a[i] = frame[b];
        else         din_a[i] = (h == 0) ? {4'h0, frame[b][3:0]} : {4'h0, frame[b][7:4]};
        dv_a[i]   = 1'b1;
        last_a[i] = fin;
        step();
        dv_a[i]   = 1'b0;
        last_a[i] = 1'b0;
        if (!fin) begin
          n_chk++;
          if (done_a[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL early_done[%0d]: got %b, expected 0", i, done_a[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({busy_a[i], done_a[i], ok_a[i], fv_a[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got %b, expected 0000", i,
                 {busy_a[i], done_a[i], ok_a[i], fv_a[i]});
      end
      n_chk++;
      if (crc_a[i] !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL reset_crc[%0d]: got %h, expected 00000000", i, crc_a[i]);
      end
    end
    reset = 1'b0;
    dv_a[0]  = 1'b1;
    din_a[0] = 8'h55;
    step();
    step();
    dv_a[0] = 1'b0;
    n_chk++;
    if (crc_a[0] !== 32'h0000_0000 || busy_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_din: got crc %h busy %b, expected 00000000 0",
               crc_a[0], busy_a[0]);
    end
  endtask

  task automatic test_check(input int i);
    pulse_start(i);
    n_chk++;
    if (busy_a[i] !== 1'b1 || crc_a[i] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL check_open[%0d]: got busy %b crc %h, expected 1 00000000", i, busy_a[i],
               crc_a[i]);
    end
    load_msg();
    send_frame(i, 1'b1);
    n_chk++;
    if (done_a[i] !== 1'b1 || crc_a[i] !== 32'hCBF4_3926 || ok_a[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL check_done[%0d]: got done %b crc %h ok %b, expected 1 cbf43926 0", i,
               done_a[i], crc_a[i], ok_a[i]);
    end
    step();
    n_chk++;
    if (done_a[i] !== 1'b0 || busy_a[i] !== 1'b0 || crc_a[i] !== 32'hCBF4_3926) begin
      n_fail++;
      $display("FAIL check_after[%0d]: got done %b busy %b crc %h, expected 0 0 cbf43926", i,
               done_a[i], busy_a[i], crc_a[i]);
    end
  endtask

  // Drains an 8-bit FCS with ready held high and checks the closing status.
  task automatic drain_tx8(input string name);
    logic [31:0] fcs;
    fcs = 32'hCBF4_3926;
    rdy_a[2] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      n_chk++;
      if (fv_a[2] !== 1'b1 || fd_a[2] !== fcs[b*8 +: 8]) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got valid %b data %h, expected 1 %h", name, b, fv_a[2],
                 fd_a[2], fcs[b*8 +: 8]);
      end
      step();
    end
    rdy_a[2] = 1'b0;
    n_chk++;
    if (done_a[2] !== 1'b1 || ok_a[2] !== 1'b1 || fv_a[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_close: got done %b ok %b valid %b, expected 1 1 0", name, done_a[2],
               ok_a[2], fv_a[2]);
    end
    step();
    n_chk++;
    if (done_a[2] !== 1'b0 || busy_a[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got done %b busy %b, expected 0 0", name, done_a[2], busy_a[2]);
    end
  endtask

  task automatic test_tx_w8();
    pulse_start(2);
    load_msg();
    send_frame(2, 1'b1);
    drain_tx8("tx8");
  endtask

  task automatic test_tx_w4_stall();
    logic [31:0] fcs;
    logic [7:0]  prev;
    bit          prev_stall;
    int          k;
    int          cyc;
    fcs        = 32'hCBF4_3926;
    prev       = 8'h00;
    prev_stall = 1'b0;
    k          = 0;
    cyc        = 0;
    pulse_start(3);
    load_msg();
    send_frame(3, 1'b1);
    while (k < 8 && cyc < 64) begin
      rdy_a[3] = (cyc % 4 == 0) || (cyc % 4 == 3);
      n_chk++;
      if (fv_a[3] !== 1'b1 || fd_a[3] !== {4'h0, fcs[k*4 +: 4]}) begin
        n_fail++;
        $display("FAIL tx4_beat%0d: got valid %b data %h, expected 1 %h", k, fv_a[3], fd_a[3],
                 fcs[k*4 +: 4]);
      end
      if (prev_stall) begin
        n_chk++;
        if (fd_a[3] !== prev) begin
          n_fail++;
          $display("FAIL tx4_hold: got %h, expected %h", fd_a[3], prev);
        end
      end
      prev       = fd_a[3];
      prev_stall = !rdy_a[3];
      if (rdy_a[3]) k++;
      step();
      cyc++;
    end
    rdy_a[3] = 1'b0;
    n_chk++;
    if (k != 8) begin
      n_fail++;
      $display("FAIL tx4_timeout: got %0d beats, expected 8", k);
    end
    n_chk++;
    if (done_a[3] !== 1'b1 || ok_a[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL tx4_close: got done %b ok %b, expected 1 1", done_a[3], ok_a[3]);
    end
    step();
  endtask

  task automatic test_residue(input int i);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start(i);
      load_msg();
      frame.push_back(8'h26);
      frame.push_back(8'h39);
      frame.push_back(8'hF4);
      frame.push_back(pass == 0 ? 8'hCB : 8'hCA);
      send_frame(i, 1'b1);
      n_chk++;
      if (done_a[i] !== 1'b1 || ok_a[i] !== (pass == 0)) begin
        n_fail++;
        $display("FAIL residue[%0d] pass %0d: got done %b ok %b, expected 1 %b", i, pass,
                 done_a[i], ok_a[i], pass == 0);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(0);
    frame = '{8'h31, 8'h32};
    send_frame(0, 1'b0);
    start_a[0] = 1'b1;
    dv_a[0]    = 1'b1;
    din_a[0]   = 8'h31;
    step();
    start_a[0] = 1'b0;
    dv_a[0]    = 1'b0;
    n_chk++;
    if (crc_a[0] !== 32'h0000_0000 || busy_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_with_beat: got crc %h busy %b, expected 00000000 1", crc_a[0],
               busy_a[0]);
    end
    load_msg();
    send_frame(0, 1'b1);
    n_chk++;
    if (done_a[0] !== 1'b1 || crc_a[0] !== 32'hCBF4_3926) begin
      n_fail++;
      $display("FAIL abort_then_frame: got done %b crc %h, expected 1 cbf43926", done_a[0],
               crc_a[0]);
    end
    pulse_start(0);
    n_chk++;
    if (busy_a[0] !== 1'b1 || done_a[0] !== 1'b0 || crc_a[0] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL start_in_done: got busy %b done %b crc %h, expected 1 0 00000000",
               busy_a[0], done_a[0], crc_a[0]);
    end
    send_frame(0, 1'b1);
    n_chk++;
    if (done_a[0] !== 1'b1 || crc_a[0] !== 32'hCBF4_3926) begin
      n_fail++;
      $display("FAIL back_to_back: got done %b crc %h, expected 1 cbf43926", done_a[0],
               crc_a[0]);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    pulse_start(0);
    frame = '{8'h31, 8'h32, 8'h33, 8'h34};
    send_frame(0, 1'b0);
    reset = 1'b1;
    #1;
    n_chk++;
    if (busy_a[0] !== 1'b0 || crc_a[0] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL async_reset: got busy %b crc %h, expected 0 00000000", busy_a[0],
               crc_a[0]);
    end
    step();
    reset = 1'b0;
    step();
    pulse_start(0);
    load_msg();
    send_frame(0, 1'b1);
    n_chk++;
    if (done_a[0] !== 1'b1 || crc_a[0] !== 32'hCBF4_3926) begin
      n_fail++;
      $display("FAIL after_reset_frame: got done %b crc %h, expected 1 cbf43926", done_a[0],
               crc_a[0]);
    end
    step();
    pulse_start(2);
    load_msg();
    send_frame(2, 1'b1);
    reset = 1'b1;
    #1;
    n_chk++;
    if (fv_a[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_fcs: got valid %b, expected 0", fv_a[2]);
    end
    step();
    reset = 1'b0;
    rdy_a[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if (fv_a[2] !== 1'b0 || done_a[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_in_fcs_quiet: got valid %b done %b, expected 0 0", fv_a[2],
                 done_a[2]);
      end
    end
    rdy_a[2] = 1'b0;
  endtask

  task automatic test_abort_fcs();
    pulse_start(2);
    load_msg();
    send_frame(2, 1'b1);
    step();
    n_chk++;
    if (fv_a[2] !== 1'b1 || fd_a[2] !== 8'h26) begin
      n_fail++;
      $display("FAIL fcs_stalled: got valid %b data %h, expected 1 26", fv_a[2], fd_a[2]);
    end
    pulse_start(2);
    n_chk++;
    if (fv_a[2] !== 1'b0 || done_a[2] !== 1'b0 || busy_a[2] !== 1'b1 ||
        crc_a[2] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL abort_fcs: got valid %b done %b busy %b crc %h, expected 0 0 1 00000000",
               fv_a[2], done_a[2], busy_a[2], crc_a[2]);
    end
    send_frame(2, 1'b1);
    drain_tx8("refcs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk    = 1'b0;
    reset  = 1'b1;
    n_chk  = 0;
    n_fail = 0;
    idle_all();
    test_reset();
    test_check(0);
    test_check(1);
    test_tx_w8();
    test_tx_w4_stall();
    test_residue(0);
    test_residue(1);
    test_back_to_back();
    test_reset_mid_frame();
    test_abort_fcs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_crc32_engine.md
ETH_CRC32_ENGINE -- requirements
Module: eth_crc32_engine

Interface
REQ-001 Parameter DATA_W, default 4, meaning data path width in bits per cycle; legal values 4 and 8 only.
REQ-002 Parameter MODE_TX, default 1, meaning 1 = append and serialise FCS after last data, 0 = check only.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse, loads register with 0xFFFFFFFF and opens a frame.
REQ-006 din_valid  input  1  din carries frame data this cycle.
REQ-007 din  input  DATA_W  frame data, bit 0 is earliest on the wire.
REQ-008 din_last  input  1  qualifies final din_valid beat of the frame.
REQ-009 fcs_ready  input  1  downstream accepts the current fcs_data beat.
REQ-010 fcs_valid  output  1  fcs_data holds a valid FCS beat (MODE_TX=1 only; tied 0 otherwise).
REQ-011 fcs_data  output  DATA_W  FCS beat, bit 0 earliest on the wire.
REQ-012 crc_out  output  32  reflected, complemented CRC of data accepted so far.
REQ-013 done  output  1  one-cycle pulse when a frame closes.
REQ-014 crc_ok  output  1  valid with done: register equals residue 0xC704DD7B.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Register update per bit SHALL be: fb = reg[31] ^ d; reg = {reg[30:0],1'b0} ^ (fb ? 0x04C11DB7 : 0); DATA_W bits applied per accepted beat, din[0] first, in one cycle.
REQ-017 crc_out SHALL equal bitreverse(~reg), combinational from reg.
REQ-018 States: IDLE, ACCUM, FCS_TX, DONE.
REQ-019 IDLE: start -> ACCUM with reg = 0xFFFFFFFF; din_valid ignored.
REQ-020 ACCUM: din_valid updates reg; din_valid & din_last -> FCS_TX if MODE_TX=1, else DONE.
REQ-021 FCS_TX: fcs_valid high; fcs_data = slice k of bitreverse(~reg_frozen), k = 0..(32/DATA_W)-1, slice 0 = bits [DATA_W-1:0]; k advances only on fcs_valid & fcs_ready; last slice accepted -> DONE.
REQ-022 fcs_data and fcs_valid SHALL hold stable while fcs_valid & !fcs_ready.
REQ-023 In FCS_TX the emitted beats SHALL also be fed into reg so that, at DONE, reg equals residue 0xC704DD7B.
REQ-024 DONE: done = 1, crc_ok = (reg == 0xC704DD7B), one cycle, then IDLE; crc_out holds until next start.
REQ-025 start in ACCUM or FCS_TX SHALL abort the frame: reg reloaded, k cleared, next state ACCUM, no done pulse.
REQ-026 start in DONE SHALL take priority: done still pulses that cycle, next state ACCUM.
REQ-027 start and din_valid in the same cycle: reload takes precedence, beat discarded.
REQ-028 din_valid in FCS_TX or DONE SHALL be ignored.
REQ-029 Beat counter k SHALL be ceil(log2(32/DATA_W)) bits and wrap to 0 on leaving FCS_TX.
REQ-030 Latency: crc_out reflects a beat one cycle after its acceptance edge.

Reset
REQ-031 On reset: state IDLE, reg 0xFFFFFFFF, k 0, fcs_valid 0, done 0, crc_ok 0, busy 0; crc_out = 0x00000000 accordingly.
REQ-032 Reset mid-frame SHALL discard the frame with no done pulse and no further fcs_valid.

Structure
REQ-033 Shared package SHALL hold CRC32_POLY 0x04C11DB7, CRC32_INIT 0xFFFFFFFF, CRC32_RESIDUE 0xC704DD7B and the state enumeration.
REQ-034 One sub-module crc32_step (combinational, parameter DATA_W, curr reg + data -> next reg) SHALL implement REQ-016; the FSM, counter and serialiser stay in the top.

Verification
REQ-035 DATA_W=8, MODE_TX=0: start, bytes ASCII "123456789", last on '9' -> crc_out = 0xCBF43926, done one pulse.
REQ-036 DATA_W=4, MODE_TX=0: same string as 18 nibbles low first -> crc_out = 0xCBF43926.
REQ-037 DATA_W=8, MODE_TX=1: "123456789", fcs_ready=1 -> fcs_data 0x26,0x39,0xF4,0xCB, then done with crc_ok = 1.
REQ-038 DATA_W=4, MODE_TX=1, fcs_ready toggled 1-0-0-1...: eight nibbles 6,2,9,3,4,F,B,C each held stable while stalled; crc_ok = 1.
REQ-039 MODE_TX=0: "123456789" plus bytes 0x26,0x39,0xF4,0xCB -> crc_ok = 1; corrupt one bit -> crc_ok = 0.
REQ-040 reset asserted after 4 beats, then start and full frame -> no done until frame end, result 0xCBF43926; start mid-FCS_TX -> fcs_valid drops next cycle.
